// File: rtl/p405s_icu_fill_buf_rd_pkg.sv
// Shared ICU definitions: line geometry, fill-state encoding and word width.
package p405s_icu_fill_buf_rd_pkg;

  localparam int unsigned ICU_LINE_WORDS = 8;
  localparam int unsigned ICU_IDX_W      = 3;
  localparam int unsigned ICU_WORD_W     = 32;

  typedef enum logic {
    StIdle   = 1'b0,
    StActive = 1'b1
  } fill_state_e;

endpackage

// File: rtl/p405s_icu_fill_buf_rd_reg32.sv
// ICU enabled 32-bit register cell; holds its value when en_i is low, no reset.
module p405s_icu_fill_buf_rd_reg32
  import p405s_icu_fill_buf_rd_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic [0:ICU_WORD_W-1] d_i,
  output logic [0:ICU_WORD_W-1] q_o
);

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/p405s_icu_fill_buf_rd.sv
// I-cache line fill buffer: captures fill words in wrapped critical-word-first order,
// forwards the critical word to fetch, and drains words to the array in arrival order.
module p405s_icu_fill_buf_rd
  import p405s_icu_fill_buf_rd_pkg::*;
#(
  parameter int unsigned LINE_WORDS = ICU_LINE_WORDS,
  parameter int unsigned IDX_W      = ICU_IDX_W
) (
  input  logic             CB,
  input  logic             Reset,
  input  logic             fillStart,
  input  logic [IDX_W-1:0] startIdx,
  input  logic             wrVal,
  input  logic [0:31]      wrData,
  output logic             arrWrVal,
  output logic [IDX_W-1:0] arrWrIdx,
  output logic [0:31]      arrWrData,
  input  logic             arrAck,
  output logic             bypVal,
  output logic [0:31]      bypData,
  output logic             lineDone,
  output logic             fillErr
);

  localparam int unsigned     CntW    = IDX_W + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(LINE_WORDS);

  fill_state_e      state_q;
  logic [CntW-1:0]  wr_cnt_q;
  logic [CntW-1:0]  rd_cnt_q;
  logic [IDX_W-1:0] start_idx_q;
  logic             byp_val_q;
  logic [0:31]      byp_data_q;
  logic             line_done_q;
  logic             fill_err_q;

  logic             open_fill;
  logic [IDX_W-1:0] base_idx;
  logic [CntW-1:0]  wr_cnt_eff;
  logic [IDX_W-1:0] wr_slot;
  logic             wr_accept;
  logic             wr_discard;
  logic             start_discard;
  logic             rd_take;
  logic             rd_last;

  logic [0:31]      buf_q [LINE_WORDS];

  // A fill opened this cycle already owns a same-cycle write as word 0.
  always_comb begin
    open_fill     = (state_q == StIdle) && fillStart;
    base_idx      = open_fill ? startIdx : start_idx_q;
    wr_cnt_eff    = open_fill ? '0 : wr_cnt_q;
    wr_slot       = base_idx + wr_cnt_eff[IDX_W-1:0];
    wr_accept     = wrVal && (open_fill || ((state_q == StActive) && (wr_cnt_q != CntFull)));
    wr_discard    = wrVal && !wr_accept;
    start_discard = fillStart && (state_q == StActive);
    rd_take       = arrWrVal && arrAck;
    rd_last       = rd_take && (rd_cnt_q == CntFull - 1'b1);
  end

  always_ff @(posedge CB) begin
    if (Reset) begin
      state_q     <= StIdle;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      start_idx_q <= '0;
      byp_val_q   <= 1'b0;
      byp_data_q  <= '0;
      line_done_q <= 1'b0;
      fill_err_q  <= 1'b0;
    end else begin
      byp_val_q   <= 1'b0;
      line_done_q <= 1'b0;

      if (open_fill) begin
        state_q     <= StActive;
        start_idx_q <= startIdx;
        rd_cnt_q    <= '0;
      end

      if (wr_accept) begin
        wr_cnt_q <= wr_cnt_eff + 1'b1;
        if (wr_cnt_eff == '0) begin
          byp_val_q  <= 1'b1;
          byp_data_q <= wrData;
        end
      end else if (open_fill) begin
        wr_cnt_q <= '0;
      end

      // Never coincides with open_fill: nothing is offered while idle.
      if (rd_take) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
        if (rd_last) begin
          state_q     <= StIdle;
          line_done_q <= 1'b1;
        end
      end

      if (wr_discard || start_discard) begin
        fill_err_q <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < LINE_WORDS; i++) begin : g_word
    p405s_icu_fill_buf_rd_reg32 u_word (
      .clk_i (CB),
      .en_i  (wrVal && wr_accept && (wr_slot == IDX_W'(i))),
      .d_i   (wrData),
      .q_o   (buf_q[i])
    );
  end

  // Data is gated so the offered word reads as zero whenever nothing is offered.
  always_comb begin
    arrWrVal  = rd_cnt_q < wr_cnt_q;
    arrWrIdx  = start_idx_q + rd_cnt_q[IDX_W-1:0];
    arrWrData = arrWrVal ? buf_q[arrWrIdx] : '0;
  end

  assign bypVal   = byp_val_q;
  assign bypData  = byp_data_q;
  assign lineDone = line_done_q;
  assign fillErr  = fill_err_q;

endmodule

// File: doc/p405s_icu_fill_buf_rd.md
P405S_ICU_FILL_BUF_RD -- requirements
Module: p405s_icu_fill_buf_rd

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8, meaning words per cache line (power of two).
REQ-002 SHALL have parameter IDX_W, default 3, meaning log2(LINE_WORDS).
REQ-003 CB  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 fillStart  input  1  one-cycle pulse that opens a line fill.
REQ-006 startIdx  input  IDX_W  critical-word index, sampled with fillStart.
REQ-007 wrVal  input  1  a fill word is present on wrData this cycle.
REQ-008 wrData  input  [0:31]  fill word from the capture register.
REQ-009 arrWrVal  output  1  buffered word offered to the I-cache array.
REQ-010 arrWrIdx  output  IDX_W  word index within the line of the offered word.
REQ-011 arrWrData  output  [0:31]  offered word.
REQ-012 arrAck  input  1  array accepts the offered word this cycle.
REQ-013 bypVal  output  1  one-cycle forward of the critical word to fetch.
REQ-014 bypData  output  [0:31]  critical word.
REQ-015 lineDone  output  1  one-cycle pulse: all LINE_WORDS words have been accepted by the array.
REQ-016 fillErr  output  1  sticky protocol-error flag.

Function
REQ-017 SHALL implement states IDLE and ACTIVE; IDLE->ACTIVE on fillStart; ACTIVE->IDLE in the cycle after the last arrAck.
REQ-018 SHALL hold a LINE_WORDS x 32 buffer, a write counter wrCnt (0..LINE_WORDS) and a read counter rdCnt (0..LINE_WORDS), both cleared on fillStart.
REQ-019 SHALL store the k-th accepted wrVal word at slot (startIdx+k) mod LINE_WORDS, wrapping past LINE_WORDS-1 to 0.
REQ-020 SHALL accept wrVal in the same cycle as fillStart as word k=0.
REQ-021 SHALL assert bypVal with bypData=word0 exactly one cycle after word k=0 is accepted.
REQ-022 SHALL offer words in arrival order; arrWrVal high iff rdCnt<wrCnt; arrWrIdx=(startIdx+rdCnt) mod LINE_WORDS.
REQ-023 SHALL give a minimum latency of one cycle from wrVal to arrWrVal, with no combinational path from wrData to arrWrData.
REQ-024 SHALL hold arrWrVal, arrWrIdx and arrWrData stable until arrAck.
REQ-025 SHALL increment rdCnt on arrAck&&arrWrVal, and SHALL ignore arrAck when arrWrVal is low.
REQ-026 SHALL process a simultaneous write and acknowledge in the same cycle independently.
REQ-027 SHALL pulse lineDone in the cycle after the acknowledge that makes rdCnt=LINE_WORDS.
REQ-028 SHALL discard wrVal in IDLE or when wrCnt=LINE_WORDS, and SHALL set fillErr.
REQ-029 SHALL ignore fillStart in ACTIVE, and SHALL set fillErr.
REQ-030 SHALL clear fillErr only by Reset.

Reset
REQ-031 SHALL, on Reset, enter IDLE and zero wrCnt, rdCnt, arrWrVal, arrWrIdx, bypVal, lineDone and fillErr; arrWrData and bypData SHALL be 0.
REQ-032 SHALL abandon a fill when Reset arrives mid-fill, with no lineDone and no further arrWrVal.
REQ-033 SHALL ignore fillStart and wrVal while Reset is high.
REQ-034 SHALL leave buffer contents undefined after reset.

Structure
REQ-035 SHALL take the LINE_WORDS and IDX_W defaults and the state encoding (IDLE=0, ACTIVE=1) from the shared ICU package.
REQ-036 SHALL build each buffer word from one instance of the existing ICU enabled 32-bit register cell, with its enable = wrVal && slot-select.
REQ-037 SHALL use no other sub-module.

Verification
REQ-038 Reset; fillStart, startIdx=5, wrVal on 8 consecutive cycles with data 0xA0..0xA7, arrAck tied high -> bypVal/0xA0 one cycle later; arrWrIdx sequence 5,6,7,0,1,2,3,4; lineDone one cycle after the 8th acknowledge.
REQ-039 Same fill with arrAck low for 10 cycles, then high -> arrWrVal=1, idx 5, data 0xA0 held throughout; the 8 words drain in order; no loss.
REQ-040 wrVal in IDLE, then a 9th wrVal after 8 words, then fillStart while ACTIVE -> fillErr=1 and sticky; buffer and counters are unchanged.
REQ-041 Reset asserted after 3 of 8 words -> next cycle arrWrVal=0, lineDone=0, state IDLE; a new fill with startIdx=0 then completes normally.
REQ-042 Alternate wrVal and arrAck in the same cycle with random gaps (seed fixed) -> scoreboard matches index and data for all 8 words; exactly one lineDone.
